// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus master: port map, opcodes and FSM states.
package io_bus_pkg;

    localparam logic [7:0] ADDR_OUT0   = 8'h00;
    localparam logic [7:0] ADDR_READY  = 8'h04;
    localparam logic [7:0] ADDR_OUT1   = 8'h08;
    localparam logic [7:0] ADDR_SWITCH = 8'h0C;
    localparam logic [7:0] ADDR_VALID  = 8'h10;

    typedef enum logic [1:0] {
        OP_WR0    = 2'b00,
        OP_WR1    = 2'b01,
        OP_IN_RD  = 2'b10,
        OP_RAW_RD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RDY_SET,
        POLL,
        GAP,
        IN_RD,
        RDY_CLR,
        RESP
    } state_e;

endpackage

// File: rtl/io_poll_timer.sv
// Poll-phase timing: a gap counter that marks every POLL_GAP-th cycle as a
// poll slot, and a 20-bit timeout counter covering the whole poll phase.
module io_poll_timer #(
    parameter int          POLL_GAP = 4,
    parameter logic [19:0] TIMEOUT  = 20'hF_FFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic gap_done,
    output logic timeout
);

    // Cycle 0 of each gap period is the POLL cycle; the last one hands back to POLL.
    localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP - 1);
    localparam logic [19:0] TMO_LAST = TIMEOUT - 20'd1;

    logic [7:0]  gap_cnt;
    logic [19:0] tmo_cnt;

    assign gap_done = run && (gap_cnt == GAP_LAST);
    assign timeout  = run && (tmo_cnt == TMO_LAST);

    // Both counters restart on clear and advance only during poll-phase cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
            tmo_cnt <= '0;
        end else if (clear) begin
            gap_cnt <= '0;
            tmo_cnt <= '0;
        end else if (run) begin
            gap_cnt <= gap_done ? 8'd0 : gap_cnt + 8'd1;
            if (tmo_cnt != 20'hF_FFFF) begin
                tmo_cnt <= tmo_cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/io_bus_master.sv
// Command-driven IO bus master: plain writes, raw valid reads, and a
// ready/valid handshaked input read with polling gap and timeout.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int          POLL_GAP = 4,
    parameter logic [19:0] TIMEOUT  = 20'hF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    input  logic [31:0] io_din
);

    state_e      state_q, state_d;
    op_e         op_q;
    logic [31:0] data_q;
    logic [31:0] capture_q;
    logic        err_q;
    logic        first_q;
    logic        v_ref_q;
    logic        gap_done;
    logic        timeout;
    logic        timer_run;
    logic        toggled;
    logic        unused_din_bits;

    assign unused_din_bits = ^io_din[31:5];

    assign timer_run = ((state_q == POLL) || (state_q == GAP)) && (op_q == OP_IN_RD);
    assign toggled   = !first_q && (io_din[0] != v_ref_q);

    io_poll_timer #(
        .POLL_GAP(POLL_GAP),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == RDY_SET),
        .run     (timer_run),
        .gap_done(gap_done),
        .timeout (timeout)
    );

    // Next-state and all bus/response outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        io_addr   = ADDR_OUT0;
        io_dout   = '0;
        io_we     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_WR0, OP_WR1: state_d = WR;
                        OP_IN_RD:       state_d = RDY_SET;
                        OP_RAW_RD:      state_d = POLL;
                    endcase
                end
            end
            WR: begin
                io_we   = 1'b1;
                io_addr = (op_q == OP_WR1) ? ADDR_OUT1 : ADDR_OUT0;
                io_dout = data_q;
                state_d = RESP;
            end
            RDY_SET: begin
                io_we   = 1'b1;
                io_addr = ADDR_READY;
                io_dout = 32'd1;
                state_d = POLL;
            end
            POLL: begin
                io_addr = ADDR_VALID;
                if (op_q == OP_RAW_RD)  state_d = RESP;
                else if (toggled)       state_d = IN_RD;
                else if (timeout)       state_d = RDY_CLR;
                else if (gap_done)      state_d = POLL;
                else                    state_d = GAP;
            end
            GAP: begin
                if (timeout)            state_d = RDY_CLR;
                else if (gap_done)      state_d = POLL;
            end
            IN_RD: begin
                io_addr = ADDR_SWITCH;
                state_d = RDY_CLR;
            end
            RDY_CLR: begin
                io_we   = 1'b1;
                io_addr = ADDR_READY;
                io_dout = 32'd0;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = capture_q;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops straight to IDLE, abandoning any command.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Command fields are latched at acceptance and held for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_WR0;
            data_q <= '0;
        end else if (cmd_valid && cmd_ready) begin
            op_q   <= op_e'(cmd_op);
            data_q <= cmd_data;
        end
    end

    // The first poll of a handshake records the valid level; later polls compare against it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b0;
            v_ref_q <= 1'b0;
        end else if (state_q == RDY_SET) begin
            first_q <= 1'b1;
        end else if ((state_q == POLL) && (op_q == OP_IN_RD) && first_q) begin
            first_q <= 1'b0;
            v_ref_q <= io_din[0];
        end
    end

    // Response payload: cleared per command, filled by the read that completes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capture_q <= '0;
            err_q     <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            capture_q <= '0;
            err_q     <= 1'b0;
        end else if ((state_q == POLL) && (op_q == OP_RAW_RD)) begin
            capture_q <= {31'b0, io_din[0]};
        end else if (state_q == IN_RD) begin
            capture_q <= {27'b0, io_din[4:0]};
        end else if (((state_q == POLL) || (state_q == GAP)) && (state_d == RDY_CLR)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master with a small peripheral model.
module tb_io_bus_master;
    import io_bus_pkg::*;

    localparam int G   = 4;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, rsp_err, io_we;
    logic [31:0] rsp_data, io_dout, io_din;
    logic [7:0]  io_addr;

    int total = 0;
    int bad   = 0;

    io_bus_master #(.POLL_GAP(G), .TIMEOUT(20'(TMO))) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_din(io_din)
    );

    always #5 clk = ~clk;

    // Peripheral model configuration (written only by the test tasks).
    logic        valid_init = 1'b0;
    int          toggle_after = 0;   // valid flips after this many polls; 0 = never
    int          poll_base = 0;
    logic [4:0]  sw = '0;
    logic [31:0] junk = '0;

    // Observations (written only by the monitors).
    int          cyc = 0;
    int          poll_cnt = 0;
    int          polls_done = 0;
    int          wr_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
    logic [7:0]  wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    int          acc_cyc [0:255];
    logic [31:0] acc_data [0:255];
    logic        valid_line;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) polls_done <= poll_cnt;

    always_comb valid_line = valid_init ^ ((toggle_after != 0) && ((polls_done - poll_base) >= toggle_after));

    always_comb begin
        case (io_addr)
            ADDR_SWITCH: io_din = {junk[31:5], sw};
            ADDR_VALID:  io_din = {junk[31:1], valid_line};
            default:     io_din = junk;
        endcase
    end

    always @(negedge clk) begin
        if (io_we && wr_cnt < 256) begin
            wr_addr[wr_cnt] = io_addr;
            wr_data[wr_cnt] = io_dout;
            wr_cnt = wr_cnt + 1;
        end
        if (io_addr == ADDR_VALID) poll_cnt = poll_cnt + 1;
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
        if (cmd_valid && cmd_ready && !rst && acc_cnt < 256) begin
            acc_cyc[acc_cnt]  = cyc;
            acc_data[acc_cnt] = cmd_data;
            acc_cnt = acc_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command and wait (bounded) for its response strobe.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] d, output int lat,
                           output logic [31:0] rd, output logic re, output bit ok, output bit idle_after);
        bit acc = 0;
        ok = 0; lat = 0; rd = '0; re = 1'b0; idle_after = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = 1; break; end
        end
        if (!acc) begin cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = i; rd = rsp_data; re = rsp_err; ok = 1; break; end
        end
        if (ok) begin
            @(negedge clk);
            idle_after = !rsp_valid && cmd_ready;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({rsp_valid, rsp_data, rsp_err, io_addr, io_dout, io_we} !== '0) begin
            $display("FAIL reset_outputs: got rsp_valid=%b rsp_data=%h rsp_err=%b io_addr=%h io_dout=%h io_we=%b want all zero",
                     rsp_valid, rsp_data, rsp_err, io_addr, io_dout, io_we);
            bad++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
            bad++;
        end
    endtask

    task automatic test_write();
        int lat; logic [31:0] rd; logic re; bit ok, idle_after;
        for (int n = 0; n < 5; n++) begin
            logic [1:0]  op    = (n == 0) ? 2'b00 : 2'($urandom_range(0, 1));
            logic [31:0] d     = (n == 0) ? 32'h1F : $urandom;
            logic [7:0]  exp_a = op[0] ? ADDR_OUT1 : ADDR_OUT0;
            int          wbase = wr_cnt;
            run_cmd(op, d, lat, rd, re, ok, idle_after);
            total++;
            if (!ok) begin $display("FAIL write_rsp: got no response want one"); bad++; continue; end
            total++;
            if (lat != 2) begin $display("FAIL write_latency: got %0d want 2", lat); bad++; end
            total++;
            if ({rd, re} !== 33'd0) begin $display("FAIL write_rsp_fields: got data=%h err=%b want 0/0", rd, re); bad++; end
            total++;
            if (wr_cnt - wbase != 1 || wr_addr[wbase] !== exp_a || wr_data[wbase] !== d) begin
                $display("FAIL write_bus: got n=%0d addr=%h data=%h want n=1 addr=%h data=%h",
                         wr_cnt - wbase, wr_addr[wbase], wr_data[wbase], exp_a, d);
                bad++;
            end
            total++;
            if (!idle_after) begin $display("FAIL write_resp_one_cycle: got not idle want idle"); bad++; end
        end
    endtask

    task automatic test_raw_read();
        int lat; logic [31:0] rd; logic re; bit ok, idle_after;
        for (int n = 0; n < 4; n++) begin
            int wbase;
            valid_init = (n < 2) ? n[0] : 1'($urandom);
            toggle_after = 0;
            junk = $urandom;
            wbase = wr_cnt;
            run_cmd(2'b11, $urandom, lat, rd, re, ok, idle_after);
            total++;
            if (!ok) begin $display("FAIL raw_rsp: got no response want one"); bad++; continue; end
            total++;
            if (lat != 2 || rd !== {31'b0, valid_init} || re !== 1'b0 || wr_cnt != wbase) begin
                $display("FAIL raw_read: got lat=%0d data=%h err=%b writes=%0d want lat=2 data=%h err=0 writes=0",
                         lat, rd, re, wr_cnt - wbase, {31'b0, valid_init});
                bad++;
            end
        end
    endtask

    // Reference: first poll at +2, one re-poll every G cycles; the (k+1)-th poll sees
    // the change, then switch read, ready clear and response follow one cycle each.
    // With no change the poll phase lasts TMO cycles, then ready clear and response.
    task automatic do_handshake(input string name, input logic vinit, input int k, input logic [4:0] s);
        int lat; logic [31:0] rd; logic re; bit ok, idle_after;
        int          exp_lat  = (k == 0) ? TMO + 3 : 2 + k * G + 3;
        logic [31:0] exp_data = (k == 0) ? 32'd0 : {27'b0, s};
        logic        exp_err  = (k == 0);
        int          wbase;
        valid_init = vinit; toggle_after = k; sw = s; junk = $urandom;
        poll_base = poll_cnt;
        wbase = wr_cnt;
        run_cmd(2'b10, $urandom, lat, rd, re, ok, idle_after);
        total++;
        if (!ok) begin $display("FAIL %s rsp: got no response want one", name); bad++; return; end
        total++;
        if (lat != exp_lat) begin $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); bad++; end
        total++;
        if (rd !== exp_data || re !== exp_err) begin
            $display("FAIL %s rsp_fields: got data=%h err=%b want data=%h err=%b", name, rd, re, exp_data, exp_err);
            bad++;
        end
        total++;
        if (wr_cnt - wbase != 2 || wr_addr[wbase] !== ADDR_READY || wr_data[wbase] !== 32'd1
            || wr_addr[wbase+1] !== ADDR_READY || wr_data[wbase+1] !== 32'd0) begin
            $display("FAIL %s ready_writes: got n=%0d first=%h/%h second=%h/%h want n=2 04/1 04/0", name,
                     wr_cnt - wbase, wr_addr[wbase], wr_data[wbase], wr_addr[wbase+1], wr_data[wbase+1]);
            bad++;
        end
        total++;
        if (!idle_after) begin $display("FAIL %s resp_one_cycle: got not idle want idle", name); bad++; end
    endtask

    task automatic test_rising();  do_handshake("rising", 1'b0, 3, 5'h15); endtask
    task automatic test_falling(); do_handshake("falling", 1'b1, 2, 5'($urandom)); endtask
    task automatic test_timeout(); do_handshake("timeout", 1'($urandom), 0, 5'($urandom)); endtask

    task automatic test_random_handshake();
        for (int n = 0; n < 4; n++)
            do_handshake("random_hs", 1'($urandom), $urandom_range(1, 5), 5'($urandom));
    endtask

    task automatic test_reset_mid_gap();
        int wbase, wbase2, rbase;
        bit acc = 0;
        valid_init = 1'b0; toggle_after = 0;
        wbase = wr_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = 1; break; end
        end
        total++;
        if (!acc) begin $display("FAIL rst_gap_accept: got not ready want ready"); bad++; cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        total++;
        if (wr_cnt - wbase != 1) begin $display("FAIL rst_gap_pre_writes: got %0d want 1", wr_cnt - wbase); bad++; end
        wbase2 = wr_cnt; rbase = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_data, rsp_err, io_addr, io_dout, io_we} !== '0) begin
            $display("FAIL rst_gap_outputs: got rsp_valid=%b io_addr=%h io_dout=%h io_we=%b want all zero",
                     rsp_valid, io_addr, io_dout, io_we);
            bad++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (wr_cnt != wbase2 || rsp_cnt != rbase || cmd_ready !== 1'b1) begin
            $display("FAIL rst_gap_abort: got writes=%0d rsps=%0d ready=%b want 0 0 1",
                     wr_cnt - wbase2, rsp_cnt - rbase, cmd_ready);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        int abase, wbase, rbase;
        @(posedge clk); #1;
        abase = acc_cnt; wbase = wr_cnt; rbase = rsp_cnt;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = $urandom;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            cmd_data = $urandom;
        end
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (acc_cnt - abase != 3) begin
            $display("FAIL b2b_accepts: got %0d want 3", acc_cnt - abase); bad++;
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (acc_cyc[abase+i] - acc_cyc[abase+i-1] != 3) begin
                    $display("FAIL b2b_spacing: got %0d want 3", acc_cyc[abase+i] - acc_cyc[abase+i-1]); bad++;
                end
            end
            total++;
            if (wr_cnt - wbase != 3) begin
                $display("FAIL b2b_writes: got %0d want 3", wr_cnt - wbase); bad++;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if (wr_addr[wbase+i] !== ADDR_OUT1 || wr_data[wbase+i] !== acc_data[abase+i]) begin
                        $display("FAIL b2b_write_value: got %h/%h want %h/%h",
                                 wr_addr[wbase+i], wr_data[wbase+i], ADDR_OUT1, acc_data[abase+i]);
                        bad++;
                    end
                end
            end
        end
        total++;
        if (rsp_cnt - rbase != 3) begin $display("FAIL b2b_rsps: got %0d want 3", rsp_cnt - rbase); bad++; end
    endtask

    initial begin
        test_reset();
        test_write();
        test_raw_read();
        test_rising();
        test_falling();
        test_random_handshake();
        test_timeout();
        test_reset_mid_gap();
        test_random_handshake();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter POLL_GAP, default 4, cycles between successive polls of the valid port (legal 1..255).
REQ-002 Parameter TIMEOUT, default 20'hF_FFFF, maximum poll-phase cycles before abort.
REQ-003 clk  input  1  system clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command request from user logic.
REQ-006 cmd_op  input  2  opcode: 00 write out0, 01 write out1, 10 handshaked input read, 11 raw valid read.
REQ-007 cmd_data  input  32  write data for opcodes 00/01; ignored otherwise.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-009 rsp_valid  output  1  one-cycle response strobe.
REQ-010 rsp_data  output  32  response data, valid only with rsp_valid.
REQ-011 rsp_err  output  1  timeout flag, valid only with rsp_valid.
REQ-012 io_addr  output  8  IO bus address.
REQ-013 io_dout  output  32  IO bus write data.
REQ-014 io_we  output  1  IO bus write enable, one cycle per write.
REQ-015 io_din  input  32  IO bus read data, combinational from peripheral for the current io_addr.

Function
REQ-016 Port map SHALL be: 0x00 out0, 0x04 ready, 0x08 out1, 0x0C switch input (bits 4:0), 0x10 valid (bit 0).
REQ-017 FSM states SHALL be IDLE, WR, RDY_SET, POLL, GAP, IN_RD, RDY_CLR, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; command fields are registered at acceptance (cycle N).
REQ-019 Opcode 00/01: WR at N+1 drives io_we=1, io_addr=0x00/0x08, io_dout=cmd_data; RESP at N+2 with rsp_data=0, rsp_err=0.
REQ-020 Opcode 11: POLL-type read at N+1 (io_addr=0x10), captures {31'b0, io_din[0]}; RESP at N+2.
REQ-021 Opcode 10 step 1: RDY_SET at N+1 writes io_dout=1 to 0x04.
REQ-022 Opcode 10 step 2: first POLL at N+2 drives 0x10 and stores io_din[0] as reference v_ref.
REQ-023 Opcode 10 step 3: GAP waits POLL_GAP-1 cycles, then POLL resamples; repeat while io_din[0]==v_ref.
REQ-024 Opcode 10 step 4: on io_din[0]!=v_ref (either edge), IN_RD next cycle drives 0x0C and captures {27'b0, io_din[4:0]}.
REQ-025 Opcode 10 step 5: RDY_CLR writes io_dout=0 to 0x04; RESP next cycle with captured data, rsp_err=0.
REQ-026 A 20-bit timeout counter SHALL clear at RDY_SET and count every POLL/GAP cycle; on reaching TIMEOUT go to RDY_CLR, then RESP with rsp_data=0, rsp_err=1.
REQ-027 Minimum opcode-10 latency with an immediate toggle is acceptance to rsp_valid = 1+1+1+POLL_GAP+1+1 cycles (N+POLL_GAP+5 in total).
REQ-028 Outside active states io_addr=0x00, io_dout=0, io_we=0; io_we is never high in POLL, GAP or IN_RD.
REQ-029 RESP lasts exactly one cycle, then IDLE; a new command may be accepted in the cycle after RESP.
REQ-030 cmd_valid outside IDLE SHALL be ignored; no queuing.

Reset
REQ-031 On rst: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_err=0, io_addr=0x00, io_dout=0, io_we=0, counters=0, v_ref=0.
REQ-032 Reset mid-operation SHALL abort without issuing any further IO write; no response is produced for the aborted command.

Structure
REQ-033 Shared package io_bus_pkg SHALL hold port address constants, opcode encodings and the FSM state typedef.
REQ-034 Gap and timeout counting SHALL live in one sub-module io_poll_timer (inputs: clear, run; outputs: gap_done, timeout).

Verification
REQ-035 Opcode 00, cmd_data=32'h1F -> io_we=1, io_addr=0x00, io_dout=32'h1F at N+1; rsp_valid at N+2.
REQ-036 Opcode 10, valid 0 toggles to 1 after 3 polls, switches=5'h15 -> writes 1 then 0 to 0x04, rsp_data=32'h15, rsp_err=0.
REQ-037 Opcode 10, valid starts 1 and falls -> falling edge accepted, rsp_data = switch value.
REQ-038 Opcode 10, TIMEOUT=100, valid never toggles -> 0x04 cleared, rsp_err=1, rsp_data=0.
REQ-039 rst asserted during GAP -> all outputs at reset values on the next clock edge, no rsp_valid, no io_we.
REQ-040 Back-to-back opcode 01 commands held on cmd_valid -> accepted every 3 cycles, one io_we each.
